// File: rtl/pong_pkg.sv
// Shared Pong constants: screen geometry, ball parameters, frame-tick row and ball FSM states.
// Used by ball_ctrl and pong_frame_tick.
package pong_pkg;

    localparam int unsigned X_MAX       = 639;
    localparam int unsigned Y_MAX       = 479;
    localparam int unsigned BALL_SIZE   = 8;
    localparam int unsigned BALL_VEL    = 2;
    localparam int unsigned VEL_MAX     = 5;
    localparam int unsigned SERVE_DELAY = 60;
    localparam int unsigned SCORE_HOLD  = 30;

    localparam logic [9:0] CENTRE_L = 10'd316;
    localparam logic [9:0] CENTRE_T = 10'd236;
    localparam logic [9:0] TICK_ROW = 10'd481;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StServeWait = 2'd1,
        StPlay      = 2'd2,
        StScored    = 2'd3
    } ball_state_e;

endpackage

// File: rtl/pong_frame_tick.sv
// One-clock-per-frame strobe, asserted when the raster sits at column 0 of row TICK_ROW.
module pong_frame_tick
    import pong_pkg::*;
(
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic       tick_o
);

    assign tick_o = (x_i == 10'd0) && (y_i == TICK_ROW);

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball engine: serve/play/score FSM, once-per-frame motion, wall/paddle bounces, goals.
// Build option: define SPEEDUP_EN to add one pixel/frame per paddle hit, capped at VEL_MAX.
module ball_ctrl
    import pong_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic       serve_i,
    input  logic [9:0] pad1_t_i,
    input  logic [9:0] pad1_b_i,
    input  logic [9:0] pad1_l_i,
    input  logic [9:0] pad1_r_i,
    input  logic [9:0] pad2_t_i,
    input  logic [9:0] pad2_b_i,
    input  logic [9:0] pad2_l_i,
    input  logic [9:0] pad2_r_i,
    output logic       ball_on_o,
    output logic [9:0] ball_l_o,
    output logic [9:0] ball_t_o,
    output logic       score1_o,
    output logic       score2_o,
    output logic       hit_o,
    output logic       in_play_o
);

    ball_state_e state_q;
    logic [5:0]  cnt_q;
    logic [9:0]  ball_l_q, ball_t_q;
    logic        x_pos_q, y_pos_q;
    logic        score1_q, score2_q, hit_q;
    logic [9:0]  speed;
    logic        tick;

`ifdef SPEEDUP_EN
    logic [2:0] speed_q;
    assign speed = 10'(speed_q);
`else
    assign speed = 10'(BALL_VEL);
`endif

    pong_frame_tick u_frame_tick (
        .x_i    (x_i),
        .y_i    (y_i),
        .tick_o (tick)
    );

    logic [9:0] ball_r, ball_b, step_l, step_t;
    logic       y_pos_nxt, x_pos_nxt, hit_r, hit_l, goal_r, goal_l;

    always_comb begin
        ball_r = ball_l_q + 10'(BALL_SIZE - 1);
        ball_b = ball_t_q + 10'(BALL_SIZE - 1);

        y_pos_nxt = y_pos_q;
        if (ball_t_q <= speed) begin
            y_pos_nxt = 1'b1;
        end else if (ball_b >= 10'(Y_MAX) - speed) begin
            y_pos_nxt = 1'b0;
        end

        hit_r = x_pos_q && (ball_r >= pad1_l_i - speed) && (ball_r <= pad1_r_i) &&
                (ball_b >= pad1_t_i) && (ball_t_q <= pad1_b_i);
        hit_l = !x_pos_q && (ball_l_q <= pad2_r_i + speed) && (ball_l_q >= pad2_l_i) &&
                (ball_b >= pad2_t_i) && (ball_t_q <= pad2_b_i);
        goal_r = x_pos_q && (ball_r >= 10'(X_MAX) - speed);
        goal_l = !x_pos_q && (ball_l_q <= speed);

        // Motion uses the post-bounce direction so a bounce never steps into the obstacle.
        x_pos_nxt = (hit_r || hit_l) ? !x_pos_q : x_pos_q;
        step_l    = x_pos_nxt ? ball_l_q + speed : ball_l_q - speed;
        step_t    = y_pos_nxt ? ball_t_q + speed : ball_t_q - speed;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= 6'd0;
            ball_l_q <= CENTRE_L;
            ball_t_q <= CENTRE_T;
            x_pos_q  <= 1'b1;
            y_pos_q  <= 1'b1;
            score1_q <= 1'b0;
            score2_q <= 1'b0;
            hit_q    <= 1'b0;
`ifdef SPEEDUP_EN
            speed_q  <= 3'(BALL_VEL);
`endif
        end else begin
            score1_q <= 1'b0;
            score2_q <= 1'b0;
            hit_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (serve_i) begin
                        state_q <= StServeWait;
                        cnt_q   <= 6'd0;
`ifdef SPEEDUP_EN
                        speed_q <= 3'(BALL_VEL);
`endif
                    end
                end
                StServeWait: begin
                    if (tick) begin
                        if (cnt_q == 6'(SERVE_DELAY - 1)) begin
                            state_q <= StPlay;
                            cnt_q   <= 6'd0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                StPlay: begin
                    if (tick) begin
                        if (hit_r || hit_l) begin
                            x_pos_q  <= x_pos_nxt;
                            y_pos_q  <= y_pos_nxt;
                            ball_l_q <= step_l;
                            ball_t_q <= step_t;
                            hit_q    <= 1'b1;
`ifdef SPEEDUP_EN
                            if (speed_q < 3'(VEL_MAX)) begin
                                speed_q <= speed_q + 3'd1;
                            end
`endif
                        end else if (goal_r || goal_l) begin
                            // Ball freezes; x_pos already points at the conceding player.
                            score2_q <= goal_r;
                            score1_q <= goal_l;
                            state_q  <= StScored;
                            cnt_q    <= 6'd0;
                        end else begin
                            y_pos_q  <= y_pos_nxt;
                            ball_l_q <= step_l;
                            ball_t_q <= step_t;
                        end
                    end
                end
                StScored: begin
                    if (tick) begin
                        if (cnt_q == 6'(SCORE_HOLD - 1)) begin
                            state_q  <= StServeWait;
                            cnt_q    <= 6'd0;
                            ball_l_q <= CENTRE_L;
                            ball_t_q <= CENTRE_T;
`ifdef SPEEDUP_EN
                            speed_q  <= 3'(BALL_VEL);
`endif
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ball_on_o = (state_q != StScored) && (x_i >= ball_l_q) && (x_i <= ball_r) &&
                       (y_i >= ball_t_q) && (y_i <= ball_b);
    assign ball_l_o  = ball_l_q;
    assign ball_t_o  = ball_t_q;
    assign score1_o  = score1_q;
    assign score2_o  = score2_q;
    assign hit_o     = hit_q;
    assign in_play_o = (state_q == StPlay);

endmodule
